// File: rtl/dnn_hex_pkg.sv
// Shared definitions for the multi-digit seven-segment display peripheral:
// register map, CTRL bit positions and the segment type.
package dnn_hex_pkg;

    localparam logic [3:0] ADDR_VALUE  = 4'd0;
    localparam logic [3:0] ADDR_CTRL   = 4'd1;
    localparam logic [3:0] ADDR_BLANK  = 4'd2;
    localparam logic [3:0] ADDR_BLINK  = 4'd3;
    localparam logic [3:0] ADDR_RAWSEL = 4'd4;
    localparam logic [3:0] ADDR_RAW0   = 4'd8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_LZS    = 1;

    // Segment vector, bit0 = a .. bit6 = g.
    typedef logic [6:0] seg_t;

    // Active-low: all segments off.
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (g..a), glyphs 0-9, A, b, C, d, E, F.
import dnn_hex_pkg::*;

module hex_seg_decoder (
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/avalon_hex_display.sv
// Avalon-MM seven-segment display controller: N_DIGITS digits with blanking,
// blinking, raw segment override and leading-zero suppression.
import dnn_hex_pkg::*;

module avalon_hex_display #(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    output logic [7*N_DIGITS-1:0] hex
);

    localparam int VW    = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BLINK_DIV);

    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
        $error("avalon_hex_display: N_DIGITS must be in 1..8");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("avalon_hex_display: BLINK_DIV must be >= 2");
    end

    logic [VW-1:0]       value_q;
    logic [1:0]          ctrl_q;
    logic [N_DIGITS-1:0] blank_q;
    logic [N_DIGITS-1:0] blink_q;
    logic [N_DIGITS-1:0] rawsel_q;
    seg_t                raw_q [N_DIGITS];

    logic                raw_hit;
    logic [2:0]          raw_idx;
    logic                rd_req;
    logic                ack_q;
    logic [31:0]         rd_mux;
    logic [CNT_W-1:0]    blink_cnt_q;
    logic                phase_q;
    logic                blink_wr;
    logic [N_DIGITS-1:0] suppress;
    logic                scan_run;
    seg_t                dec_seg [N_DIGITS];
    logic [7*N_DIGITS-1:0] hex_d;
    logic                unused_wdata;

    assign raw_hit = (address >= ADDR_RAW0) && ((address - ADDR_RAW0) < 4'(N_DIGITS));
    assign raw_idx = 3'(address - ADDR_RAW0);
    assign blink_wr = write && (address == ADDR_BLINK);
    assign unused_wdata = ^writedata;

    // Register file. A write wins over a read issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the RAW array is a handful of flops, not a RAM, so resetting it is cheap and safe.
            value_q  <= '0;
            ctrl_q   <= '0;
            blank_q  <= '0;
            blink_q  <= '0;
            rawsel_q <= '0;
            for (int i = 0; i < N_DIGITS; i++) raw_q[i] <= '0;
        end else if (write) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            case (address)
                ADDR_VALUE:  value_q  <= writedata[VW-1:0];
                ADDR_CTRL:   ctrl_q   <= writedata[1:0];
                ADDR_BLANK:  blank_q  <= writedata[N_DIGITS-1:0];
                ADDR_BLINK:  blink_q  <= writedata[N_DIGITS-1:0];
                ADDR_RAWSEL: rawsel_q <= writedata[N_DIGITS-1:0];
                default: if (raw_hit) raw_q[raw_idx] <= writedata[6:0];
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_VALUE:  rd_mux[VW-1:0]       = value_q;
            ADDR_CTRL:   rd_mux[1:0]          = ctrl_q;
            ADDR_BLANK:  rd_mux[N_DIGITS-1:0] = blank_q;
            ADDR_BLINK:  rd_mux[N_DIGITS-1:0] = blink_q;
            ADDR_RAWSEL: rd_mux[N_DIGITS-1:0] = rawsel_q;
            default: if (raw_hit) rd_mux[6:0] = raw_q[raw_idx];
        endcase
    end

    // One fixed wait state: capture on the first read cycle, release on the second.
    assign rd_req      = read && !write;
    assign waitrequest = rd_req && !ack_q && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            readdata <= '0;
        end else begin
            ack_q <= rd_req && !ack_q;
            if (rd_req && !ack_q) readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_wr) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Scan from the most significant digit; a raw digit or a non-zero digit ends the run.
    always_comb begin
        suppress = '0;
        scan_run = 1'b1;
        // NOTE: blocking assignments here carry scan_run from one loop iteration to the next.
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            suppress[i] = scan_run && !rawsel_q[i] && (value_q[4*i +: 4] == 4'h0);
            scan_run    = scan_run && !rawsel_q[i] && (suppress[i] || blank_q[i]);
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        hex_seg_decoder u_dec (
            .nibble (value_q[4*g +: 4]),
            .seg    (dec_seg[g])
        );
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!ctrl_q[CTRL_ENABLE] || blank_q[i])       hex_d[7*i +: 7] = SEG_BLANK;
            else if (blink_q[i] && phase_q)               hex_d[7*i +: 7] = SEG_BLANK;
            else if (rawsel_q[i])                         hex_d[7*i +: 7] = ~raw_q[i];
            else if (ctrl_q[CTRL_LZS] && suppress[i])     hex_d[7*i +: 7] = SEG_BLANK;
            else                                          hex_d[7*i +: 7] = dec_seg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hex <= '1;
        else        hex <= hex_d;
    end

endmodule

// File: tb/tb_avalon_hex_display.sv
// Scoreboard bench for avalon_hex_display (N_DIGITS=6, BLINK_DIV=4): stimulus
// queues expected read data and display patterns, a negedge monitor compares them.
module tb_avalon_hex_display;

    localparam int N   = 6;
    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] DK = 7'b1111111;
    localparam logic [41:0] ALL_DARK = {42{1'b1}};

    logic          clk;
    logic          rst_n;
    logic [3:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [7*N-1:0] hex;
    logic          probe;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [41:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t hex_q[$];

    avalon_hex_display #(.N_DIGITS(N), .BLINK_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .hex         (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] pack(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    // Monitor: a completed read and a display probe each consume one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && read && !write && !waitrequest) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", readdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, 64'(readdata), 64'(e.val));
            end
        end
        if (probe) begin
            if (hex_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL hex_unexpected: got 0x%0h, expected no probe", hex);
            end else begin
                e = hex_q.pop_front();
                check(e.name, 64'(hex), 64'(e.val));
            end
        end
    end

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        check("wr_waitrequest", 64'(waitrequest), 64'd0);
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back('{name, 42'(exp)});
        address = a; read = 1'b1;
        @(negedge clk);
        check({name, "_ws1"}, 64'(waitrequest), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_ws0"}, 64'(waitrequest), 64'd0);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic hex_cycle(input logic [41:0] exp, input string name);
        hex_q.push_back('{name, exp});
        probe = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [41:0] lit;
        logic [41:0] dark0;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0; probe = 1'b0;
        #12;
        check("reset_hex", 64'(hex), 64'(ALL_DARK));
        check("reset_waitrequest", 64'(waitrequest), 64'd0);
        check("reset_readdata", 64'(readdata), 64'd0);
        rst_n = 1'b1;
        settle();
        hex_cycle(ALL_DARK, "hex_disabled");

        // Plain decode
        wr(4'd1, 32'h1);
        wr(4'd0, 32'hA5);
        settle();
        hex_cycle(pack(S0, S0, S0, S0, SA, S5), "hex_a5");

        // Leading-zero suppression
        wr(4'd1, 32'h3);
        wr(4'd0, 32'h100);
        settle();
        hex_cycle(pack(DK, DK, DK, S1, S0, S0), "hex_lzs_100");
        wr(4'd0, 32'h0);
        settle();
        hex_cycle(pack(DK, DK, DK, DK, DK, S0), "hex_lzs_0");

        // Raw segments and register reads
        wr(4'd4, 32'h02);
        wr(4'd9, 32'h49);
        settle();
        hex_cycle(pack(DK, DK, DK, DK, 7'b0110110, S0), "hex_raw1");
        rd(4'd9, 32'h49, "rd_raw1");
        rd(4'd1, 32'h3, "rd_ctrl");
        rd(4'd4, 32'h2, "rd_rawsel");
        wr(4'd8, 32'hFFFF_FFFF);
        rd(4'd8, 32'h7F, "rd_raw0_mask");

        // Blink: lit 4 cycles, dark 4, restart on rewrite of BLINK
        wr(4'd1, 32'h1);
        wr(4'd4, 32'h0);
        lit   = pack(S0, S0, S0, S0, S0, S0);
        dark0 = pack(S0, S0, S0, S0, S0, DK);
        wr(4'd3, 32'h1);
        settle();
        for (int j = 1; j <= 4; j++) hex_cycle(lit, "hex_blink_lit");
        for (int j = 5; j <= 6; j++) hex_cycle(dark0, "hex_blink_dark");
        wr(4'd3, 32'h1);
        settle();
        for (int j = 1; j <= 4; j++) hex_cycle(lit, "hex_blink_restart_lit");
        hex_cycle(dark0, "hex_blink_restart_dark");
        rd(4'd3, 32'h1, "rd_blink");
        wr(4'd3, 32'h0);

        // Blanking, unmapped addresses, simultaneous read+write
        wr(4'd2, 32'h3F);
        settle();
        hex_cycle(ALL_DARK, "hex_blank_all");
        rd(4'd5, 32'h0, "rd_unmapped5");
        rd(4'd15, 32'h0, "rd_unmapped15");
        rd(4'd2, 32'h3F, "rd_blank");
        wr(4'd14, 32'h55);
        rd(4'd14, 32'h0, "rd_raw6_unmapped");
        address = 4'd0; writedata = 32'hFF12_3456; write = 1'b1; read = 1'b1;
        @(negedge clk);
        check("rdwr_waitrequest", 64'(waitrequest), 64'd0);
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        rd(4'd0, 32'h0012_3456, "rd_value_rdwr");

        // Reset during a read wait state
        wr(4'd2, 32'h0);
        settle();
        address = 4'd0; read = 1'b1;
        @(negedge clk);
        check("rst_rd_ws1", 64'(waitrequest), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_rd_waitrequest", 64'(waitrequest), 64'd0);
        check("rst_rd_hex", 64'(hex), 64'(ALL_DARK));
        read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        settle();
        rd(4'd0, 32'h0, "rd_rst_value");
        rd(4'd1, 32'h0, "rd_rst_ctrl");
        rd(4'd2, 32'h0, "rd_rst_blank");
        rd(4'd3, 32'h0, "rd_rst_blink");
        rd(4'd4, 32'h0, "rd_rst_rawsel");
        rd(4'd8, 32'h0, "rd_rst_raw0");
        rd(4'd9, 32'h0, "rd_rst_raw1");
        hex_cycle(ALL_DARK, "hex_after_rst");

        settle();
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check("hex_queue_drained", 64'(hex_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
